// File: rtl/mmc3_scanline_irq_pkg.sv
// Shared definitions for the MMC3 scanline IRQ block.
// Register select codes as presented by the upstream mapper decode:
//   $C000 latch, $C001 reload, $E000 disable/ack, $E001 enable.
package mmc3_scanline_irq_pkg;

  typedef enum logic [1:0] {
    REG_LATCH   = 2'd0,
    REG_RELOAD  = 2'd1,
    REG_DISABLE = 2'd2,
    REG_ENABLE  = 2'd3
  } reg_sel_e;

endpackage

// File: rtl/mmc3_scanline_irq_if.sv
// Mapper-side bus into the scanline IRQ engine.
//   enable      : mapper selected; low forces the IRQ engine idle
//   reg_we      : one-cycle register write strobe
//   reg_sel     : register select (see reg_sel_e)
//   reg_data    : write data ($C000 only)
//   ppu_a12     : raw PPU A12, asynchronous to m2
//   irq         : active-low IRQ, 0 = pending
//   counter_dbg : current scanline counter value
// master = mapper logic driving the engine, slave = the engine itself.
interface mmc3_scanline_irq_if;
  import mmc3_scanline_irq_pkg::*;

  logic       enable;
  logic       reg_we;
  logic [1:0] reg_sel;
  logic [7:0] reg_data;
  logic       ppu_a12;
  logic       irq;
  logic [7:0] counter_dbg;

  modport master (
    output enable, reg_we, reg_sel, reg_data, ppu_a12,
    input  irq, counter_dbg
  );

  modport slave (
    input  enable, reg_we, reg_sel, reg_data, ppu_a12,
    output irq, counter_dbg
  );

endinterface

// File: rtl/mmc3_scanline_irq_a12_edge_filter.sv
// PPU A12 synchronizer, low-time filter and rising-edge detector.
//   i_clk     : M2 clock
//   i_rst     : synchronous active-high reset
//   i_a12     : raw PPU A12 (asynchronous)
//   o_a12_clk : one-cycle pulse on a filtered A12 rise
// A rise only counts when A12 was seen low for at least A12_LOW_MIN
// cycles; the low counter saturates so long low periods never wrap.
module mmc3_scanline_irq_a12_edge_filter
  import mmc3_scanline_irq_pkg::*;
#(
  parameter int unsigned A12_LOW_MIN  = 3,
  parameter int unsigned LOW_CNT_BITS = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_a12,
  output logic o_a12_clk
);

  localparam logic [LOW_CNT_BITS-1:0] LOW_MIN = LOW_CNT_BITS'(A12_LOW_MIN);

  logic                    r_a12_s1;
  logic                    r_a12_s2;
  logic                    r_a12_prev;
  logic [LOW_CNT_BITS-1:0] r_low_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_a12_s1   <= 1'b0;
      r_a12_s2   <= 1'b0;
      r_a12_prev <= 1'b0;
      r_low_cnt  <= '0;
    end else begin
      r_a12_s1   <= i_a12;
      r_a12_s2   <= r_a12_s1;
      r_a12_prev <= r_a12_s2;
      if (r_a12_s2)
        r_low_cnt <= '0;
      else if (r_low_cnt != '1)
        r_low_cnt <= r_low_cnt + LOW_CNT_BITS'(1);
    end
  end

  // r_low_cnt still holds the low run that preceded this rise.
  assign o_a12_clk = r_a12_s2 & ~r_a12_prev & (r_low_cnt >= LOW_MIN);

endmodule

// File: rtl/mmc3_scanline_irq.sv
// MMC3-style scanline IRQ engine clocked by M2.
//   m2    : clock, all state updates on the rising edge
//   reset : synchronous active-high reset
//   bus   : mapper-side interface (slave modport), carries enable,
//           register write strobe/select/data, raw PPU A12, the
//           active-low irq output and the counter debug value
// OLD_IRQ_MODE = 0 fires whenever a clock leaves the counter at 0;
// OLD_IRQ_MODE = 1 fires only on nonzero->0 or reload-flag reloads.
module mmc3_scanline_irq
  import mmc3_scanline_irq_pkg::*;
#(
  parameter int unsigned A12_LOW_MIN  = 3,
  parameter int unsigned OLD_IRQ_MODE = 0,
  parameter int unsigned LOW_CNT_BITS = 2
) (
  input logic                 m2,
  input logic                 reset,
  mmc3_scanline_irq_if.slave  bus
);

  logic       w_a12_clk;
  logic [7:0] w_clk_cnt;
  logic       w_fire;

  logic [7:0] r_latch;
  logic [7:0] r_counter;
  logic       r_reload;
  logic       r_irq_en;
  logic       r_pending;

  mmc3_scanline_irq_a12_edge_filter #(
    .A12_LOW_MIN  (A12_LOW_MIN),
    .LOW_CNT_BITS (LOW_CNT_BITS)
  ) u_a12_filter (
    .i_clk     (m2),
    .i_rst     (reset),
    .i_a12     (bus.ppu_a12),
    .o_a12_clk (w_a12_clk)
  );

  // Clock result and IRQ decision use only pre-edge state, so a
  // same-cycle register write can override them in the sequential block.
  always_comb begin
    w_clk_cnt = (r_counter == '0 || r_reload) ? r_latch : r_counter - 8'd1;
    w_fire    = w_a12_clk && (w_clk_cnt == '0) && r_irq_en;
    if (OLD_IRQ_MODE != 0)
      w_fire = w_fire && (r_counter != '0 || r_reload);
  end

  always_ff @(posedge m2) begin
    if (reset) begin
      r_latch   <= '0;
      r_counter <= '0;
      r_reload  <= 1'b0;
      r_irq_en  <= 1'b0;
      r_pending <= 1'b0;
    end else if (!bus.enable) begin
      r_irq_en  <= 1'b0;
      r_pending <= 1'b0;
    end else begin
      if (w_a12_clk) begin
        r_counter <= w_clk_cnt;
        r_reload  <= 1'b0;
      end
      if (w_fire)
        r_pending <= 1'b1;
      // Later assignments win: $C001 beats the clock's counter update,
      // $E000 beats a same-cycle pending set.
      if (bus.reg_we) begin
        case (reg_sel_e'(bus.reg_sel))
          REG_LATCH:   r_latch <= bus.reg_data;
          REG_RELOAD: begin
            r_counter <= '0;
            r_reload  <= 1'b1;
          end
          REG_DISABLE: begin
            r_irq_en  <= 1'b0;
            r_pending <= 1'b0;
          end
          REG_ENABLE:  r_irq_en <= 1'b1;
        endcase
      end
    end
  end

  assign bus.irq         = ~r_pending;
  assign bus.counter_dbg = r_counter;

endmodule

// File: tb/tb_mmc3_scanline_irq.sv
// Bench for mmc3_scanline_irq: two instances (new and old IRQ mode) share
// one stimulus stream. A sample-history model predicts irq/counter every
// cycle; directed scenarios add literal expectations.
module tb_mmc3_scanline_irq;

  logic       m2 = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic       reg_we = 1'b0;
  logic [1:0] reg_sel = 2'd0;
  logic [7:0] reg_data = 8'd0;
  logic       ppu_a12 = 1'b0;

  always #5 m2 = ~m2;

  mmc3_scanline_irq_if bus0 ();
  mmc3_scanline_irq_if bus1 ();

  assign bus0.enable   = enable;
  assign bus0.reg_we   = reg_we;
  assign bus0.reg_sel  = reg_sel;
  assign bus0.reg_data = reg_data;
  assign bus0.ppu_a12  = ppu_a12;
  assign bus1.enable   = enable;
  assign bus1.reg_we   = reg_we;
  assign bus1.reg_sel  = reg_sel;
  assign bus1.reg_data = reg_data;
  assign bus1.ppu_a12  = ppu_a12;

  mmc3_scanline_irq #(
    .A12_LOW_MIN  (3),
    .OLD_IRQ_MODE (0),
    .LOW_CNT_BITS (2)
  ) dut0 (
    .m2    (m2),
    .reset (reset),
    .bus   (bus0)
  );

  mmc3_scanline_irq #(
    .A12_LOW_MIN  (3),
    .OLD_IRQ_MODE (1),
    .LOW_CNT_BITS (2)
  ) dut1 (
    .m2    (m2),
    .reset (reset),
    .bus   (bus1)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // m_hist holds A12 samples taken since reset, preceded by two zeros for
  // the cleared synchronizer stages. Entry n-2 is what the second sync
  // stage shows during the current cycle.
  int unsigned m_hist[$];
  int          m_counter = 0;
  int          m_latch   = 0;
  bit          m_reload  = 0;
  bit          m_en      = 0;
  bit          m_pend0   = 0;
  bit          m_pend1   = 0;

  function automatic bit m_a12_clk();
    int n;
    int run;
    bit s2;
    bit prev;
    n = m_hist.size();
    if (n < 3) return 1'b0;
    s2   = (m_hist[n-2] != 0);
    prev = (m_hist[n-3] != 0);
    run  = 0;
    for (int j = n - 3; j >= 0 && run < 3; j--) begin
      if (m_hist[j] != 0) break;
      run++;
    end
    return s2 && !prev && (run >= 3);
  endfunction

  task automatic model_step();
    bit clk;
    int nxt;
    if (reset) begin
      m_hist.delete();
      m_hist.push_back(0);
      m_hist.push_back(0);
      m_counter = 0; m_latch = 0; m_reload = 0;
      m_en = 0; m_pend0 = 0; m_pend1 = 0;
    end else begin
      clk = m_a12_clk();
      m_hist.push_back(ppu_a12 ? 1 : 0);
      if (m_hist.size() > 8) void'(m_hist.pop_front());
      if (!enable) begin
        m_en = 0; m_pend0 = 0; m_pend1 = 0;
      end else begin
        if (clk) begin
          nxt = (m_counter == 0 || m_reload) ? m_latch : m_counter - 1;
          if (nxt == 0 && m_en) begin
            m_pend0 = 1;
            if (m_counter != 0 || m_reload) m_pend1 = 1;
          end
          m_counter = nxt;
          m_reload  = 0;
        end
        if (reg_we) begin
          case (reg_sel)
            2'd0: m_latch = reg_data;
            2'd1: begin m_counter = 0; m_reload = 1; end
            2'd2: begin m_en = 0; m_pend0 = 0; m_pend1 = 0; end
            default: m_en = 1;
          endcase
        end
      end
    end
  endtask

  always @(posedge m2) begin
    model_step();
    #1;
    check("irq_m0", bus0.irq, !m_pend0);
    check("irq_m1", bus1.irq, !m_pend1);
    check("cnt_m0", bus0.counter_dbg, m_counter);
    check("cnt_m1", bus1.counter_dbg, m_counter);
  end

  // ---------------- directed helpers ----------------
  task automatic cyc(input int n = 1);
    repeat (n) @(negedge m2);
  endtask

  task automatic wr(input logic [1:0] s, input logic [7:0] d);
    reg_we = 1'b1; reg_sel = s; reg_data = d;
    cyc();
    reg_we = 1'b0;
  endtask

  // One A12 high sample, then lows; the counter update lands on the second
  // edge after the high sample, optionally together with a register write.
  task automatic scan(input string tag, input int exp_cnt, input int exp_i0, input int exp_i1,
                      input bit do_wr = 1'b0, input logic [1:0] s = 2'd0, input logic [7:0] d = 8'd0);
    ppu_a12 = 1'b1; cyc();
    ppu_a12 = 1'b0; cyc();
    if (do_wr) begin reg_we = 1'b1; reg_sel = s; reg_data = d; end
    cyc();
    reg_we = 1'b0;
    check({tag, "_cnt"}, bus0.counter_dbg, exp_cnt);
    check({tag, "_irq0"}, bus0.irq, exp_i0);
    check({tag, "_irq1"}, bus1.irq, exp_i1);
    cyc(2);
  endtask

  initial begin
    cyc(2);
    check("rst_irq", bus0.irq, 1);
    check("rst_cnt", bus0.counter_dbg, 0);
    reset = 1'b0; enable = 1'b1;

    // 1-cycle low pulses never pass the filter
    for (int i = 0; i < 10; i++) begin
      ppu_a12 = ~ppu_a12;
      cyc();
    end
    ppu_a12 = 1'b0; cyc();
    check("hold_cnt", bus0.counter_dbg, 0);
    check("hold_irq", bus0.irq, 1);

    // basic scanline IRQ
    wr(2'd0, 8'd3); wr(2'd1, 8'd0); wr(2'd3, 8'd0);
    scan("sl1", 3, 1, 1);
    scan("sl2", 2, 1, 1);
    scan("sl3", 1, 1, 1);
    scan("sl4", 0, 0, 0);
    wr(2'd2, 8'd0);
    check("ack_irq0", bus0.irq, 1);
    check("ack_irq1", bus1.irq, 1);

    // glitch filter
    ppu_a12 = 1'b1; cyc(); ppu_a12 = 1'b0; cyc(2);
    check("glitch_pre", bus0.counter_dbg, 3);
    ppu_a12 = 1'b1; cyc(); ppu_a12 = 1'b0; cyc(2);
    check("glitch_2low", bus0.counter_dbg, 3);
    cyc();
    ppu_a12 = 1'b1; cyc(); ppu_a12 = 1'b0; cyc(2);
    check("glitch_3low", bus0.counter_dbg, 2);

    // latch = 0
    wr(2'd0, 8'd0); wr(2'd1, 8'd0); wr(2'd3, 8'd0);
    scan("z1", 0, 0, 0);
    wr(2'd2, 8'd0); wr(2'd3, 8'd0);
    scan("z2", 0, 0, 1);
    wr(2'd1, 8'd0);
    scan("z3", 0, 0, 0);
    wr(2'd2, 8'd0);
    check("z_ack0", bus0.irq, 1);
    check("z_ack1", bus1.irq, 1);

    // $E000 together with the clock reaching 0
    wr(2'd0, 8'd2); wr(2'd1, 8'd0); wr(2'd3, 8'd0);
    scan("e1", 2, 1, 1);
    scan("e2", 1, 1, 1);
    scan("e3", 0, 1, 1, 1'b1, 2'd2, 8'd0);

    // $C001 together with a clock at counter 5
    wr(2'd0, 8'd5); wr(2'd1, 8'd0); wr(2'd3, 8'd0);
    scan("c1", 5, 1, 1);
    scan("c2", 0, 1, 1, 1'b1, 2'd1, 8'd0);
    scan("c3", 5, 1, 1);

    // enable drop with counter 2 and IRQ pending
    wr(2'd0, 8'd2); wr(2'd1, 8'd0);
    scan("d1", 2, 1, 1);
    scan("d2", 1, 1, 1);
    scan("d3", 0, 0, 0);
    scan("d4", 2, 0, 0);
    enable = 1'b0; cyc();
    check("off_irq0", bus0.irq, 1);
    check("off_irq1", bus1.irq, 1);
    check("off_cnt", bus0.counter_dbg, 2);
    scan("off", 2, 1, 1, 1'b1, 2'd1, 8'd0);
    enable = 1'b1;

    // reset during A12 activity
    ppu_a12 = 1'b1; reset = 1'b1; cyc();
    check("mid_rst_cnt", bus0.counter_dbg, 0);
    check("mid_rst_irq", bus0.irq, 1);
    reset = 1'b0;

    // randomized traffic, small latch values to hit zero often
    for (int i = 0; i < 4000; i++) begin
      reset    = ($urandom_range(0, 599) == 0);
      enable   = ($urandom_range(0, 39) != 0);
      ppu_a12  = ($urandom_range(0, 2) == 0);
      reg_we   = ($urandom_range(0, 5) == 0);
      reg_sel  = 2'($urandom_range(0, 3));
      reg_data = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 3));
      cyc();
    end
    reset = 1'b0; reg_we = 1'b0;
    cyc(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mmc3_scanline_irq.md
Name: mmc3_scanline_irq

Overview:
- MMC3-style (mapper #004/#118/#189 family) scanline IRQ engine, clocked by M2.
- Filters and edge-detects PPU A12 and runs the 8-bit reload/decrement scanline counter.
- Drives the cartridge `irq` pin consumed by the top-level.
- Register decode for $C000/$C001/$E000/$E001 is done upstream in the mapper logic, which presents a one-cycle write strobe.

Parameters:
- A12_LOW_MIN, 3: M2 cycles A12 must be seen low before a rising edge counts as a clock.
- OLD_IRQ_MODE, 0: 0 = "new" behaviour, IRQ whenever the counter is 0 after a clock; 1 = "old" behaviour, IRQ only when the counter transitions nonzero->0 or on a reload-flag reload.
- LOW_CNT_BITS, 2: width of the saturating A12-low counter. Must hold A12_LOW_MIN.

Ports:
- m2, input, 1: clock; all state updates on the rising edge.
- reset, input, 1: synchronous, active-high reset.
- enable, input, 1: mapper selected; 0 forces the IRQ engine idle.
- reg_we, input, 1: one-cycle register write strobe.
- reg_sel, input, 2: 0=$C000 latch, 1=$C001 reload, 2=$E000 disable/ack, 3=$E001 enable.
- reg_data, input, 8: write data (used by $C000 only).
- ppu_a12, input, 1: raw PPU A12 (ppu_addr_in[12]), asynchronous to m2.
- irq, output, 1: active-low IRQ; 0 = pending.
- counter_dbg, output, 8: current counter value.

Behaviour:
- **Reset** (sync, priority over everything): a12_s1=a12_s2=a12_prev=0, low_cnt=0, latch=0, counter=0, reload=0, irq_en=0, pending=0; irq=1.
- **A12 synchronizer:** a12_s1<=ppu_a12, a12_s2<=a12_s1, a12_prev<=a12_s2.
- **low_cnt:**
  - cleared when a12_s2=1.
  - incremented, saturating at all-ones, when a12_s2=0.
- **a12_clk** (combinational) = a12_s2 & ~a12_prev & (low_cnt >= A12_LOW_MIN).
  - low_cnt is evaluated as registered before the edge.
  - A12 glitches shorter than A12_LOW_MIN low cycles never clock the counter.
- **Counter step on a12_clk:**
  - if counter==0 or reload=1: counter<=latch, reload<=0.
  - else: counter<=counter-1.
- **IRQ set on a12_clk:** nxt = the new counter value.
  - OLD_IRQ_MODE=0: set pending if nxt==0 and irq_en.
  - OLD_IRQ_MODE=1: set pending if nxt==0 and irq_en and (old counter!=0 or reload was 1).
- **Register writes** (reg_we=1 at the edge):
  - $C000: latch<=reg_data.
  - $C001: counter<=0, reload<=1.
  - $E000: irq_en<=0, pending<=0.
  - $E001: irq_en<=1. pending is unchanged.
- **Simultaneous a12_clk and write:**
  - a12_clk uses the pre-edge latch/counter/reload/irq_en.
  - $C001 overrides the counter/reload results of the clock. Pending may still set from the clock's own evaluation.
  - $E000 wins over pending set: pending=0.
  - $C000 affects only later clocks.
- **enable=0:**
  - irq_en<=0, pending<=0, counter and latch held, writes ignored.
  - The synchronizer and low_cnt keep running.
- **Output:** irq = ~pending (registered, no combinational path from inputs).
- **Latency:** A12 rising before edge k → a12_s2 at k+1 → counter update and pending at k+2 → irq low after edge k+2.
- **Wrap:** latch=0 reloads 0 on every clock. In mode 0 this fires every clock; in mode 1 it fires only on reload-flag clocks.
- **counter_dbg** = counter.

Decomposition:
- Shared package/header: register select constants (REG_LATCH=0, REG_RELOAD=1, REG_DISABLE=2, REG_ENABLE=3).
- One sub-module, **a12_edge_filter**: synchronizer, low_cnt and a12_clk output, parameterised by A12_LOW_MIN and LOW_CNT_BITS.
- Counter and IRQ logic stay in the top of the block.

Test Plan:
- **Reset then hold:** reset=0, irq=1, counter_dbg=0. Toggle A12 with 1-cycle low pulses → counter_dbg stays 0, irq stays 1.
- **Basic scanline IRQ:**
  - Write $C000=3, $C001, $E001.
  - Apply A12 pulses with 4 low / 1 high cycles. counter goes 3,2,1,0.
  - irq=0 two edges after the 4th A12 rise.
  - Write $E000 → irq=1 next edge.
- **Glitch filter:** A12 low for 2 cycles then high (A12_LOW_MIN=3) → no decrement. Low for 3 cycles then high → one decrement.
- **Latch=0:**
  - OLD_IRQ_MODE=0: every filtered A12 rise sets irq=0 when enabled.
  - OLD_IRQ_MODE=1: only the clock after a $C001 write fires.
- **Collisions:**
  - $E000 in the same cycle as the clock that reaches 0 → irq stays 1.
  - $C001 in the same cycle as a clock with counter=5 → counter=0, reload=1, no IRQ.
  - The next clock loads the latch.
- **enable/reset mid-count:**
  - counter=2, pending=1, drop enable → irq=1, counter_dbg=2 held.
  - Assert reset during A12 activity → all state cleared at that edge.
